// File: rtl/decode_ctrl_queue.sv
// RV32I (+ optional M multiply) decoder feeding a small queue of decoded control bundles.
// Sits between fetch and execute; entries are decoded when pushed and the head drives the outputs.
module decode_ctrl_queue #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2,
  parameter bit EN_M_EXT   = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic            mem_to_reg,
  output logic            mem_write,
  output logic            reg_write,
  output logic            jump,
  output logic            jump_src,
  output logic            branch,
  output logic            inv_branch,
  output logic            is_end,
  output logic            illegal,
  output logic [2:0]      mem_size,
  output logic [1:0]      alu_srcA,
  output logic [1:0]      alu_srcB,
  output logic [3:0]      alu_control,
  output logic            halted
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_EQ     = 4'd10;
  localparam logic [3:0] ALU_MUL    = 4'd11;
  localparam logic [3:0] ALU_MULH   = 4'd12;
  localparam logic [3:0] ALU_MULHSU = 4'd13;
  localparam logic [3:0] ALU_MULHU  = 4'd14;

  localparam logic [1:0] SRCA_RS1  = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef struct packed {
    logic       memToReg;
    logic       memWrite;
    logic       regWrite;
    logic       jump;
    logic       jumpSrc;
    logic       branch;
    logic       invBranch;
    logic       isEnd;
    logic       illegal;
    logic [2:0] memSize;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [3:0] aluControl;
  } ctrlBundleT;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  ctrlBundleT decoded;
  logic       legal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Register and immediate ALU groups share the funct3 mapping for the base operations.
  function automatic logic [3:0] aluFromFunct3(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'd0:    op = ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [3:0] mulFromFunct3(input logic [1:0] f3);
    logic [3:0] op;
    case (f3)
      2'd0:    op = ALU_MUL;
      2'd1:    op = ALU_MULH;
      2'd2:    op = ALU_MULHSU;
      default: op = ALU_MULHU;
    endcase
    return op;
  endfunction

  always_comb begin
    decoded = '0;
    legal   = 1'b0;
    case (opcode)
      OPC_OP: begin
        decoded.regWrite = 1'b1;
        decoded.aluSrcA  = SRCA_RS1;
        decoded.aluSrcB  = SRCB_RS2;
        if (funct7 == F7_BASE) begin
          legal              = 1'b1;
          decoded.aluControl = aluFromFunct3(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'd0) begin
          legal              = 1'b1;
          decoded.aluControl = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'd5) begin
          legal              = 1'b1;
          decoded.aluControl = ALU_SRA;
        end else if (EN_M_EXT && funct7 == F7_MUL && !funct3[2]) begin
          legal              = 1'b1;
          decoded.aluControl = mulFromFunct3(funct3[1:0]);
        end
      end
      OPC_OPIMM: begin
        decoded.regWrite   = 1'b1;
        decoded.aluSrcB    = SRCB_IMM;
        decoded.aluControl = aluFromFunct3(funct3);
        // Only the shift forms constrain the upper immediate bits.
        if (funct3 == 3'd1) begin
          legal = (funct7 == F7_BASE);
        end else if (funct3 == 3'd5) begin
          legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          if (funct7 == F7_ALT) decoded.aluControl = ALU_SRA;
        end else begin
          legal = 1'b1;
        end
      end
      OPC_LOAD: begin
        legal              = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd2) ||
                             (funct3 == 3'd4) || (funct3 == 3'd5);
        decoded.regWrite   = 1'b1;
        decoded.memToReg   = 1'b1;
        decoded.aluSrcB    = SRCB_IMM;
        decoded.aluControl = ALU_ADD;
        decoded.memSize    = funct3;
      end
      OPC_STORE: begin
        legal              = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd2);
        decoded.memWrite   = 1'b1;
        decoded.aluSrcB    = SRCB_IMM;
        decoded.aluControl = ALU_ADD;
        decoded.memSize    = funct3;
      end
      OPC_BRANCH: begin
        legal             = (funct3 != 3'd2) && (funct3 != 3'd3);
        decoded.branch    = 1'b1;
        decoded.invBranch = funct3[0];
        if (!funct3[2])     decoded.aluControl = ALU_EQ;
        else if (!funct3[1]) decoded.aluControl = ALU_SLT;
        else                 decoded.aluControl = ALU_SLTU;
      end
      OPC_JAL, OPC_JALR: begin
        legal              = (opcode == OPC_JAL) || (funct3 == 3'd0);
        decoded.regWrite   = 1'b1;
        decoded.jump       = 1'b1;
        decoded.jumpSrc    = (opcode == OPC_JALR);
        decoded.aluSrcA    = SRCA_PC;
        decoded.aluSrcB    = SRCB_FOUR;
        decoded.aluControl = ALU_ADD;
      end
      OPC_LUI: begin
        legal              = 1'b1;
        decoded.regWrite   = 1'b1;
        decoded.aluSrcA    = SRCA_ZERO;
        decoded.aluSrcB    = SRCB_IMM;
        decoded.aluControl = ALU_ADD;
      end
      OPC_AUIPC: begin
        legal              = 1'b1;
        decoded.regWrite   = 1'b1;
        decoded.aluSrcA    = SRCA_PC;
        decoded.aluSrcB    = SRCB_IMM;
        decoded.aluControl = ALU_ADD;
      end
      OPC_SYSTEM: begin
        legal         = (instr == 32'h0000_0073);
        decoded.isEnd = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    // An illegal word carries only the illegal flag so execute cannot act on stray bits.
    if (!legal) begin
      decoded         = '0;
      decoded.illegal = 1'b1;
    end
  end

  ctrlBundleT       entryBundle [FIFO_DEPTH];
  logic [XLEN-1:0]  entryPc     [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtrReg;
  logic [PTR_W-1:0] rdPtrReg;
  logic [CNT_W-1:0] countReg;
  logic             haltedReg;
  logic             full;
  logic             pushEn;
  logic             popEn;
  ctrlBundleT       headBundle;

  assign full      = (countReg == CNT_W'(FIFO_DEPTH));
  assign in_ready  = !full && !haltedReg;
  assign out_valid = (countReg != '0);
  assign pushEn    = in_valid && in_ready && !flush;
  assign popEn     = out_valid && out_ready && !flush;
  assign halted    = haltedReg;

  // Entry storage needs no reset: nothing is visible until the count says it was written.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : gEntry
      ctrlBundleT      bundleReg;
      logic [XLEN-1:0] pcReg;

      always_ff @(posedge clk) begin
        if (pushEn && wrPtrReg == PTR_W'(gi)) begin
          bundleReg <= decoded;
          pcReg     <= in_pc;
        end
      end

      assign entryBundle[gi] = bundleReg;
      assign entryPc[gi]     = pcReg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wrPtrReg  <= '0;
      rdPtrReg  <= '0;
      countReg  <= '0;
      haltedReg <= 1'b0;
    end else begin
      if (pushEn) wrPtrReg <= wrPtrReg + PTR_W'(1);
      if (popEn)  rdPtrReg <= rdPtrReg + PTR_W'(1);
      case ({pushEn, popEn})
        2'b10:   countReg <= countReg + CNT_W'(1);
        2'b01:   countReg <= countReg - CNT_W'(1);
        default: countReg <= countReg;
      endcase
      if (pushEn && decoded.isEnd) haltedReg <= 1'b1;
    end
  end

  always_comb begin
    headBundle = '0;
    out_pc     = '0;
    if (out_valid) begin
      headBundle = entryBundle[rdPtrReg];
      out_pc     = entryPc[rdPtrReg];
    end
  end

  assign mem_to_reg  = headBundle.memToReg;
  assign mem_write   = headBundle.memWrite;
  assign reg_write   = headBundle.regWrite;
  assign jump        = headBundle.jump;
  assign jump_src    = headBundle.jumpSrc;
  assign branch      = headBundle.branch;
  assign inv_branch  = headBundle.invBranch;
  assign is_end      = headBundle.isEnd;
  assign illegal     = headBundle.illegal;
  assign mem_size    = headBundle.memSize;
  assign alu_srcA    = headBundle.aluSrcA;
  assign alu_srcB    = headBundle.aluSrcB;
  assign alu_control = headBundle.aluControl;

endmodule

// File: tb/tb_decode_ctrl_queue.sv
// Drives two decoder queues (without and with the multiply extension) from one stimulus stream
// and checks every cycle against a queue-of-instructions reference model.
module tb_decode_ctrl_queue;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] instr, in_pc;

  logic        inReady0, outValid0, halted0;
  logic [31:0] outPc0;
  logic        memToReg0, memWrite0, regWrite0, jump0, jumpSrc0, branch0, invBranch0, isEnd0, illegal0;
  logic [2:0]  memSize0;
  logic [1:0]  aluSrcA0, aluSrcB0;
  logic [3:0]  aluCtl0;

  logic        inReadyM, outValidM, haltedM;
  logic [31:0] outPcM;
  logic        memToRegM, memWriteM, regWriteM, jumpM, jumpSrcM, branchM, invBranchM, isEndM, illegalM;
  logic [2:0]  memSizeM;
  logic [1:0]  aluSrcAM, aluSrcBM;
  logic [3:0]  aluCtlM;

  logic [19:0] bundle0, bundleM;
  assign bundle0 = {memToReg0, memWrite0, regWrite0, jump0, jumpSrc0, branch0, invBranch0, isEnd0,
                    illegal0, memSize0, aluSrcA0, aluSrcB0, aluCtl0};
  assign bundleM = {memToRegM, memWriteM, regWriteM, jumpM, jumpSrcM, branchM, invBranchM, isEndM,
                    illegalM, memSizeM, aluSrcAM, aluSrcBM, aluCtlM};

  always #5 clk = ~clk;

  decode_ctrl_queue #(.XLEN(32), .FIFO_DEPTH(DEPTH), .EN_M_EXT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(inReady0),
    .instr(instr), .in_pc(in_pc), .out_valid(outValid0), .out_ready(out_ready), .out_pc(outPc0),
    .mem_to_reg(memToReg0), .mem_write(memWrite0), .reg_write(regWrite0), .jump(jump0),
    .jump_src(jumpSrc0), .branch(branch0), .inv_branch(invBranch0), .is_end(isEnd0),
    .illegal(illegal0), .mem_size(memSize0), .alu_srcA(aluSrcA0), .alu_srcB(aluSrcB0),
    .alu_control(aluCtl0), .halted(halted0));

  decode_ctrl_queue #(.XLEN(32), .FIFO_DEPTH(DEPTH), .EN_M_EXT(1'b1)) dutM (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(inReadyM),
    .instr(instr), .in_pc(in_pc), .out_valid(outValidM), .out_ready(out_ready), .out_pc(outPcM),
    .mem_to_reg(memToRegM), .mem_write(memWriteM), .reg_write(regWriteM), .jump(jumpM),
    .jump_src(jumpSrcM), .branch(branchM), .inv_branch(invBranchM), .is_end(isEndM),
    .illegal(illegalM), .mem_size(memSizeM), .alu_srcA(aluSrcAM), .alu_srcB(aluSrcBM),
    .alu_control(aluCtlM), .halted(haltedM));

  int nChecks = 0;
  int nFail   = 0;
  bit checkOn = 1'b0;

  logic [63:0] mq[$];
  bit          mHalted = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bundle order: {m2r, mw, rw, jump, jsrc, br, inv, end, ill, size[3], srcA[2], srcB[2], alu[4]}.
  function automatic logic [19:0] modelDecode(input logic [31:0] ins, input bit enM);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] aluTbl;
    bit          ok, m2r, mw, rw, j, js, br, inv, isEnd;
    logic [2:0]  ms;
    logic [1:0]  sa, sb;
    logic [3:0]  alu;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    aluTbl = 32'h9865_4320;   // nibble f3 -> ADD SLL SLT SLTU XOR SRL OR AND
    ok = 0; m2r = 0; mw = 0; rw = 0; j = 0; js = 0; br = 0; inv = 0; isEnd = 0;
    ms = 0; sa = 0; sb = 0; alu = 0;
    if (op == 7'h33) begin
      rw = 1;
      if (f7 == 7'h00) begin ok = 1; alu = aluTbl[4*f3 +: 4]; end
      else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) begin ok = 1; alu = (f3 == 0) ? 4'd1 : 4'd7; end
      else if (f7 == 7'h01 && enM && f3 < 4) begin ok = 1; alu = 4'd11 + {2'b00, f3[1:0]}; end
    end else if (op == 7'h13) begin
      rw = 1; sb = 1; alu = aluTbl[4*f3 +: 4];
      if (f3 == 1) ok = (f7 == 7'h00);
      else if (f3 == 5) begin ok = (f7 == 7'h00 || f7 == 7'h20); if (f7 == 7'h20) alu = 4'd7; end
      else ok = 1;
    end else if (op == 7'h03) begin
      ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5); rw = 1; m2r = 1; sb = 1; ms = f3;
    end else if (op == 7'h23) begin
      ok = (f3 < 3); mw = 1; sb = 1; ms = f3;
    end else if (op == 7'h63) begin
      ok = (f3 != 2 && f3 != 3); br = 1; inv = f3[0];
      alu = f3[2] ? (f3[1] ? 4'd4 : 4'd3) : 4'd10;
    end else if (op == 7'h6F || op == 7'h67) begin
      ok = (op == 7'h6F) || (f3 == 0); rw = 1; j = 1; js = (op == 7'h67); sa = 1; sb = 2;
    end else if (op == 7'h37) begin
      ok = 1; rw = 1; sa = 2; sb = 1;
    end else if (op == 7'h17) begin
      ok = 1; rw = 1; sa = 1; sb = 1;
    end else if (op == 7'h73) begin
      ok = (ins == 32'h0000_0073); isEnd = 1;
    end
    if (!ok) return {8'b0, 1'b1, 11'b0};
    return {m2r, mw, rw, j, js, br, inv, isEnd, 1'b0, ms, sa, sb, alu};
  endfunction

  function automatic logic [31:0] randInstr();
    logic [31:0] r;
    logic [6:0]  op;
    logic [6:0]  f7;
    r = $urandom;
    case ($urandom_range(0, 24))
      0, 1, 2, 3: op = 7'h33;
      4, 5, 6:    op = 7'h13;
      7, 8:       op = 7'h03;
      9, 10:      op = 7'h23;
      11, 12, 13: op = 7'h63;
      14:         op = 7'h6F;
      15, 16:     op = 7'h67;
      17:         op = 7'h37;
      18:         op = 7'h17;
      19:         op = 7'h73;
      20:         return 32'h0000_0073;
      default:    op = r[6:0];
    endcase
    case ($urandom_range(0, 3))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      2:       f7 = 7'h01;
      default: f7 = r[31:25];
    endcase
    return {f7, r[24:7], op};
  endfunction

  // Reference model: a queue of raw (pc, instr) pairs; decoding happens only when compared.
  initial forever begin
    bit doPush, doPop;
    @(posedge clk);
    if (!rst_n || flush) begin
      mq.delete();
      mHalted = 1'b0;
    end else begin
      doPush = in_valid && (mq.size() < DEPTH) && !mHalted;
      doPop  = (mq.size() != 0) && out_ready;
      if (doPop) begin
        $display("xact pop  pc=%h instr=%h", mq[0][63:32], mq[0][31:0]);
        void'(mq.pop_front());
      end
      if (doPush) begin
        mq.push_back({in_pc, instr});
        if (instr == 32'h0000_0073) mHalted = 1'b1;
      end
    end
  end

  initial forever begin
    bit          v;
    logic [63:0] head;
    @(negedge clk);
    if (checkOn) begin
      v    = (mq.size() != 0);
      head = v ? mq[0] : 64'h0;
      chk("out_valid", {outValidM, outValid0}, {v, v});
      chk("in_ready", {inReadyM, inReady0}, {2{(mq.size() < DEPTH) && !mHalted}});
      chk("halted", {haltedM, halted0}, {2{mHalted}});
      chk("out_pc", {outPcM, outPc0}, {2{head[63:32]}});
      chk("bundle_base", bundle0, v ? modelDecode(head[31:0], 1'b0) : 20'h0);
      chk("bundle_mext", bundleM, v ? modelDecode(head[31:0], 1'b1) : 20'h0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1;
    instr    = ins;
    in_pc    = pc;
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = 32'h0; in_pc = 32'h0;
    cyc();
    checkOn = 1'b1;
    cyc();
    rst_n = 1'b1;
    chk("rst_out_valid", outValid0, 1'b0);
    chk("rst_in_ready", inReady0, 1'b1);

    // 1: single ADD, visible the cycle after the push
    push(32'h0031_00B3, 32'h100);
    in_valid = 1'b0;
    chk("add_valid", outValid0, 1'b1);
    chk("add_reg_write", regWrite0, 1'b1);
    chk("add_alu", aluCtl0, 4'd0);
    chk("add_pc", outPc0, 32'h100);
    out_ready = 1'b1; cyc(); out_ready = 1'b0;

    // 2: fill with BNE, SRA; push attempt while full with pop must be refused
    push(32'h0020_9463, 32'h300);
    push(32'h4020_D0B3, 32'h304);
    in_valid = 1'b0;
    chk("full_in_ready", inReady0, 1'b0);
    chk("bne_branch", branch0, 1'b1);
    chk("bne_alu", aluCtl0, 4'd10);
    chk("bne_inv", invBranch0, 1'b1);
    in_valid = 1'b1; instr = 32'h0010_0093; in_pc = 32'h308; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("sra_pc", outPc0, 32'h304);
    chk("sra_alu", aluCtl0, 4'd7);
    chk("after_pop_ready", inReady0, 1'b1);
    out_ready = 1'b1; cyc();
    chk("drained_valid", outValid0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      push({12'(k + 1), 5'd2, 3'd0, 5'd1, 7'h13}, 32'h400 + 32'(4 * k));
      chk("stream_ready", inReady0, 1'b1);
      chk("stream_pc", outPc0, 32'h400 + 32'(4 * k));
    end
    in_valid = 1'b0; cyc();
    chk("stream_empty", outValid0, 1'b0);
    out_ready = 1'b0;

    // 3: MUL is illegal without the extension, ALU op 11 with it
    push(32'h0220_8033, 32'h500);
    in_valid = 1'b0;
    chk("mul_base_illegal", illegal0, 1'b1);
    chk("mul_base_rw", regWrite0, 1'b0);
    chk("mul_ext_alu", aluCtlM, 4'd11);
    chk("mul_ext_rw", regWriteM, 1'b1);
    out_ready = 1'b1; cyc(); out_ready = 1'b0;

    // 4: flush a full queue while pushing
    push(32'h0031_00B3, 32'h600);
    push(32'h0031_00B3, 32'h604);
    in_valid = 1'b1; instr = 32'h0000_A103; in_pc = 32'h608; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", outValid0, 1'b0);
    chk("flush_ready", inReady0, 1'b1);
    cyc();
    chk("flush_no_enq", outValid0, 1'b0);

    // 5: ECALL halts; following LW refused; ECALL still drains
    push(32'h0000_0073, 32'h700);
    instr = 32'h0000_A103; in_pc = 32'h704;
    chk("ecall_halted", halted0, 1'b1);
    chk("ecall_ready", inReady0, 1'b0);
    chk("ecall_is_end", isEnd0, 1'b1);
    cyc();
    in_valid = 1'b0; out_ready = 1'b1;
    chk("ecall_head_pc", outPc0, 32'h700);
    cyc();
    out_ready = 1'b0;
    chk("lw_refused", outValid0, 1'b0);
    chk("still_halted", halted0, 1'b1);

    // 6: reset with two entries queued and halted set
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("flush_unhalt", halted0, 1'b0);
    push(32'h0031_00B3, 32'h800);
    push(32'h0000_0073, 32'h804);
    in_valid = 1'b0;
    chk("pre_rst_halted", halted0, 1'b1);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk("rst_valid", outValid0, 1'b0);
    chk("rst_halted", halted0, 1'b0);
    chk("rst_ready", inReady0, 1'b1);
    chk("rst_bundle", bundle0, 20'h0);
    chk("rst_pc", outPc0, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      rst_n     = ($urandom_range(0, 149) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      instr     = randInstr();
      in_pc     = $urandom;
      cyc();
    end
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
